// File: rtl/ahb_timer_mc.sv
// ahb_timer_mc: multi-channel AHB-Lite timer.
// 64-bit counter advanced by a programmable prescaler, NCHAN compare channels
// on CLO with write-1-to-clear match flags, and a maskable level interrupt.
// Optional feature: define TIMER_MC_AUTORELOAD_EN to let CTRL.ARL reload the
// counter to 0 on a channel-0 match. Without it, ARL reads 0.
module ahb_timer_mc #(
  parameter int NCHAN   = 4,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              IRQ
);

  logic [NCHAN-1:0]       flags, ie, set_f, clr_f;
  logic [63:0]            cnt, cnt_nxt;
  logic                   en, tick, reload;
  logic [PRESC_W-1:0]     presc, pcnt;
  logic [NCHAN-1:0][31:0] cmp;
  logic                   wr, wr_cs, wr_clo, wr_chi, wr_ctrl, wr_ie;
  logic [NCHAN-1:0]       wr_c;

  assign wr      = HSEL & HWRITE;
  assign wr_cs   = wr && (HADDR == ADDR_W'(0));
  assign wr_clo  = wr && (HADDR == ADDR_W'(1));
  assign wr_chi  = wr && (HADDR == ADDR_W'(2));
  assign wr_ctrl = wr && (HADDR == ADDR_W'(3));
  assign wr_ie   = wr && (HADDR == ADDR_W'(4));

  assign tick = en && (pcnt == presc);

`ifdef TIMER_MC_AUTORELOAD_EN
  logic arl;
  // The reload fires on the tick leaving CLO==C0, so the period is C0+1 ticks.
  assign reload = arl && (cnt[31:0] == cmp[0]);
`else
  assign reload = 1'b0;
`endif

  // Value the counter takes on a tick; matches are judged against this.
  assign cnt_nxt = reload ? 64'd0 : cnt + 64'd1;

  // Per-channel write decode and match detection; a bus write to the counter
  // suppresses the tick, so no match is raised that cycle either.
  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    assign wr_c[i]  = wr && (HADDR == ADDR_W'(5 + i));
    assign set_f[i] = tick && !(wr_clo || wr_chi) && (cnt_nxt[31:0] == cmp[i]);
  end

  assign clr_f = wr_cs ? HWDATA[NCHAN-1:0] : '0;

  // Prescaler: wraps on tick, cleared by any CTRL write, frozen while disabled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     pcnt <= '0;
    else if (wr_ctrl) pcnt <= '0;
    else if (tick)    pcnt <= '0;
    else if (en)      pcnt <= pcnt + PRESC_W'(1);
  end

  // Counter: bus writes to either half win over the tick.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    cnt <= '0;
    else if (wr_clo) cnt[31:0]  <= HWDATA;
    else if (wr_chi) cnt[63:32] <= HWDATA;
    else if (tick)   cnt <= cnt_nxt;
  end

  // Match flags: a set on the same edge as a W1C clear takes priority.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) flags <= '0;
    else          flags <= (flags & ~clr_f) | set_f;
  end

  // Control, interrupt-enable and compare registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en    <= 1'b0;
      presc <= '0;
      ie    <= '0;
      cmp   <= '0;
`ifdef TIMER_MC_AUTORELOAD_EN
      arl   <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        en    <= HWDATA[0];
        presc <= HWDATA[8 +: PRESC_W];
`ifdef TIMER_MC_AUTORELOAD_EN
        arl   <= HWDATA[1];
`endif
      end
      if (wr_ie) ie <= HWDATA[NCHAN-1:0];
      for (int i = 0; i < NCHAN; i++)
        if (wr_c[i]) cmp[i] <= HWDATA;
    end
  end

  // Zero-wait-state read mux; unmapped words and bits read 0.
  always_comb begin
    HRDATA = '0;
    if (HSEL) begin
      if (HADDR == ADDR_W'(0)) HRDATA[NCHAN-1:0] = flags;
      if (HADDR == ADDR_W'(1)) HRDATA = cnt[31:0];
      if (HADDR == ADDR_W'(2)) HRDATA = cnt[63:32];
      if (HADDR == ADDR_W'(3)) begin
        HRDATA[0]            = en;
`ifdef TIMER_MC_AUTORELOAD_EN
        HRDATA[1]            = arl;
`endif
        HRDATA[8 +: PRESC_W] = presc;
      end
      if (HADDR == ADDR_W'(4)) HRDATA[NCHAN-1:0] = ie;
      for (int i = 0; i < NCHAN; i++)
        if (HADDR == ADDR_W'(5 + i)) HRDATA = cmp[i];
    end
  end

  assign IRQ = |(flags & ie);

endmodule

// File: tb/tb_ahb_timer_mc.sv
// tb_ahb_timer_mc: directed vector table for the register map plus
// hand-written sequences for prescaler, wrap, match/IRQ, W1C race,
// auto-reload and asynchronous reset.
module tb_ahb_timer_mc;

`ifdef TIMER_MC_AUTORELOAD_EN
  localparam bit ARL = 1'b1;
`else
  localparam bit ARL = 1'b0;
`endif

  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
  logic [3:0]  HADDR = '0;
  logic [31:0] HWDATA = '0, HRDATA;
  logic        IRQ;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 HCLK = ~HCLK;

  ahb_timer_mc #(.NCHAN(4), .PRESC_W(8), .ADDR_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .IRQ(IRQ)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge and occupy one cycle.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = a; HWDATA = d;
    @(negedge HCLK);
    HSEL = 1'b0; HWRITE = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    HSEL = 1'b1; HWRITE = 1'b0; HADDR = a;
    #1 chk(nm, HRDATA, exp);
    @(negedge HCLK);
    HSEL = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    // Register map vectors: counter disabled throughout, so nothing moves.
    tbl.push_back('{1'b1, 1'b0, 4'd0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd1, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd2, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd4, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd5, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'd4, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd4, 32'h0, 32'h0000_000F});
    tbl.push_back('{1'b1, 1'b1, 4'd3, 32'hFFFF_FFFE, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 32'h0, ARL ? 32'h0000_FF02 : 32'h0000_FF00});
    tbl.push_back('{1'b1, 1'b1, 4'd5, 32'h1234_5678, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd5, 32'h0, 32'h1234_5678});
    tbl.push_back('{1'b1, 1'b1, 4'd8, 32'hCAFE_F00D, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd8, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd9, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'd1, 32'hDEAD_BEEF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd1, 32'h0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 1'b0, 4'd1, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'd2, 32'h0123_4567, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd2, 32'h0, 32'h0123_4567});
    tbl.push_back('{1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'd15, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'd3, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 4'd4, 32'h0, 32'h0});

    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    idle(1);

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else begin
        HSEL = tbl[i].sel; HWRITE = 1'b0; HADDR = tbl[i].addr;
        #1 chk($sformatf("vec%0d", i), HRDATA, tbl[i].exp);
        @(negedge HCLK);
        HSEL = 1'b0;
      end
    end
    #1 chk("irq_idle", {31'b0, IRQ}, 32'h0);
    idle(1);

    // Prescaler 3: one tick every 4 cycles; disabling freezes CLO.
    wr(4'd1, 32'h0);
    wr(4'd3, 32'h0000_0301);
    idle(4);
    rd(4'd1, 32'd1, "presc_clo1");
    idle(15);
    rd(4'd1, 32'd5, "presc_clo5");
    wr(4'd3, 32'h0000_0300);
    idle(10);
    rd(4'd1, 32'd5, "presc_frozen");

    // 64-bit wrap with no flag raised.
    wr(4'd5, 32'd100); wr(4'd6, 32'd200); wr(4'd7, 32'd300); wr(4'd8, 32'd400);
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd0, 32'hF);
    wr(4'd3, 32'h1);
    rd(4'd1, 32'hFFFF_FFFF, "wrap_pre");
    rd(4'd1, 32'h0, "wrap_clo");
    rd(4'd2, 32'h0, "wrap_chi");
    rd(4'd0, 32'h0, "wrap_flags");
    wr(4'd3, 32'h0);

    // Match on channel 2 at CLO=10, IRQ next cycle, W1C clears it.
    wr(4'd7, 32'd10);
    wr(4'd4, 32'h4);
    wr(4'd1, 32'h0);
    wr(4'd0, 32'hF);
    wr(4'd3, 32'h1);
    idle(9);
    #1 chk("irq_before", {31'b0, IRQ}, 32'h0);
    rd(4'd0, 32'h0, "flags_before");
    #1 chk("irq_match", {31'b0, IRQ}, 32'h1);
    rd(4'd0, 32'h4, "flags_match");
    wr(4'd0, 32'h4);
    #1 chk("irq_cleared", {31'b0, IRQ}, 32'h0);
    rd(4'd0, 32'h0, "flags_cleared");
    wr(4'd3, 32'h0);

    // W1C on the very edge that sets flag 1: the set must survive.
    wr(4'd1, 32'd100);
    wr(4'd6, 32'd101);
    wr(4'd3, 32'h1);
    wr(4'd0, 32'h2);
    rd(4'd0, 32'h2, "w1c_race");
    wr(4'd3, 32'h0);
    wr(4'd0, 32'h2);
    rd(4'd0, 32'h0, "w1c_plain");

    // Auto-reload on channel 0 (free-runs when the feature is absent).
    wr(4'd0, 32'hF);
    wr(4'd5, 32'd4);
    wr(4'd6, 32'd999);
    wr(4'd7, 32'd999);
    wr(4'd1, 32'h0);
    wr(4'd2, 32'h0);
    wr(4'd3, 32'h3);
    for (int k = 0; k < 12; k++)
      rd(4'd1, ARL ? 32'(k % 5) : 32'(k), $sformatf("arl_clo%0d", k));
    rd(4'd0, 32'h1, "arl_flag0");
    rd(4'd3, ARL ? 32'h3 : 32'h1, "arl_ctrl");

    // Asynchronous reset while counting with IRQ high.
    wr(4'd4, 32'h1);
    #1 chk("irq_pre_rst", {31'b0, IRQ}, 32'h1);
    #1 HRESETn = 1'b0;
    #1 chk("irq_rst", {31'b0, IRQ}, 32'h0);
    for (int a = 0; a < 9; a++) begin
      HSEL = 1'b1; HADDR = 4'(a);
      #1 chk($sformatf("rst_reg%0d", a), HRDATA, 32'h0);
    end
    HSEL = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle(5);
    rd(4'd1, 32'h0, "rst_frozen");
    rd(4'd3, 32'h0, "rst_ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
